// File: rtl/coeff_loader_pkg.sv
// Shared constants for the biquad coefficient loader: frame layout, commit
// address and the power-up coefficient set (unity-gain pass-through).
package coeff_pkg;

  localparam int NUM_COEFS  = 5;
  localparam int B0         = 0;
  localparam int B1         = 1;
  localparam int B2         = 2;
  localparam int A1         = 3;
  localparam int A2         = 4;

  localparam logic [7:0] COMMIT_ADDR = 8'hFF;
  localparam int         FRAME_BITS  = 24;

  localparam logic [15:0] B0_RESET   = 16'h7FFF;
  localparam logic [15:0] COEF_RESET = 16'h0000;

  function automatic logic [15:0] coef_reset_value(input int idx);
    case (idx)
      B0:             return B0_RESET;
      B1, B2, A1, A2: return COEF_RESET;
      default:        return COEF_RESET;
    endcase
  endfunction

endpackage

// File: rtl/coeff_loader_if.sv
// SPI link from the MCU (mode 0, MSB first) into the coefficient loader.
interface coeff_loader_if;
  logic sck;
  logic cs_n;
  logic mosi;

  modport master (output sck, output cs_n, output mosi);
  modport slave  (input  sck, input  cs_n, input  mosi);
endinterface

// File: rtl/coeff_loader_rx.sv
// SPI frame receiver: synchronises the MCU pins into clk, shifts bits on sck
// rises and flags each completed frame as good (24 bits) or bad.
module spi_frame_rx
  import coeff_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  coeff_loader_if.slave  spi,
  output logic           frame_valid,
  output logic           frame_bad,
  output logic [7:0]     addr,
  output logic [15:0]    data
);

  localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX   = 5'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic [FRAME_BITS-1:0]  shreg;
  logic [4:0]             bit_cnt;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, cs_fall, cs_rise;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // cs_n synchroniser resets to idle-high so reset never fabricates an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      if (cs_fall) begin
        bit_cnt <= '0;
      end else if (!cs_s && sck_rise) begin
        shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
        if (bit_cnt != CNT_MAX) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

  // Frame is judged combinationally in the cs_n-rise cycle
  assign frame_valid = cs_rise && (bit_cnt == CNT_FRAME);
  assign frame_bad   = cs_rise && (bit_cnt != CNT_FRAME);
  assign addr        = shreg[23:16];
  assign data        = shreg[15:0];

endmodule

// File: rtl/coeff_loader.sv
// Biquad coefficient loader: SPI writes fill a shadow bank, a commit frame
// arms a whole-bank copy into the active bank on the next sample tick.
module coeff_loader
  import coeff_pkg::*;
#(
  parameter int NUM_BANDS   = 3,
  parameter int COEF_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  coeff_loader_if.slave                         spi,
  input  logic                                  sample_tick,
  output logic [NUM_BANDS*NUM_COEFS*COEF_W-1:0] coeffs,
  output logic                                  commit_pending,
  output logic                                  applied,
  output logic                                  frame_err
);

  logic        frame_valid;
  logic        frame_bad;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        is_commit;
  logic        addr_ok;

  logic [COEF_W-1:0] shadow [NUM_BANDS][NUM_COEFS];
  logic [COEF_W-1:0] active [NUM_BANDS][NUM_COEFS];

  spi_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .spi         (spi),
    .frame_valid (frame_valid),
    .frame_bad   (frame_bad),
    .addr        (addr),
    .data        (data)
  );

  assign is_commit = (addr == COMMIT_ADDR);
  assign addr_ok   = (32'(addr[7:4]) < NUM_BANDS) && (32'(addr[3:0]) < NUM_COEFS);

  // Apply is evaluated before decode: a same-cycle write only reaches shadow,
  // and a commit decoded on a tick re-arms for the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        for (int j = 0; j < NUM_COEFS; j++) begin
          shadow[k][j] <= COEF_W'(coef_reset_value(j));
          active[k][j] <= COEF_W'(coef_reset_value(j));
        end
      end
      commit_pending <= 1'b0;
      applied        <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      applied   <= 1'b0;
      frame_err <= frame_bad;
      if (sample_tick && commit_pending) begin
        active         <= shadow;
        commit_pending <= 1'b0;
        applied        <= 1'b1;
      end
      if (frame_valid) begin
        if (is_commit) begin
          commit_pending <= 1'b1;
        end else if (addr_ok) begin
          for (int k = 0; k < NUM_BANDS; k++) begin
            for (int j = 0; j < NUM_COEFS; j++) begin
              if (addr[7:4] == 4'(k) && addr[3:0] == 4'(j)) begin
                shadow[k][j] <= COEF_W'(data);
              end
            end
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
    for (genvar j = 0; j < NUM_COEFS; j++) begin : g_coef
      assign coeffs[(k*NUM_COEFS+j)*COEF_W +: COEF_W] = active[k][j];
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Directed plus randomized bench for coeff_loader against a transaction-level
// model of the shadow/active banks.
module tb_coeff_loader;
  import coeff_pkg::*;

  localparam int NB = 3;
  localparam int CW = 16;
  localparam int NC = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic [NB*NC*CW-1:0] coeffs;
  logic commit_pending, applied, frame_err;

  coeff_loader_if spi ();

  coeff_loader #(
    .NUM_BANDS   (NB),
    .COEF_W      (CW),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .spi            (spi),
    .sample_tick    (sample_tick),
    .coeffs         (coeffs),
    .commit_pending (commit_pending),
    .applied        (applied),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int err_seen = 0;
  int applied_seen = 0;
  int exp_err = 0;
  int exp_applied = 0;

  logic [15:0] m_shadow [NB][NC];
  logic [15:0] m_active [NB][NC];
  bit          m_pending;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_seen++;
    if (applied === 1'b1) applied_seen++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] coef(input int k, input int j);
    return coeffs[(k*NC+j)*CW +: CW];
  endfunction

  task automatic check_bank(input string tag);
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < NC; j++)
        chk($sformatf("%s band%0d coef%0d", tag, k, j), 32'(coef(k, j)), 32'(m_active[k][j]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < NC; j++) begin
        m_shadow[k][j] = (j == 0) ? 16'h7FFF : 16'h0000;
        m_active[k][j] = m_shadow[k][j];
      end
    m_pending = 1'b0;
  endtask

  task automatic model_apply();
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < NC; j++)
        m_active[k][j] = m_shadow[k][j];
    m_pending = 1'b0;
    exp_applied++;
  endtask

  task automatic spi_bit(input logic b);
    spi.mosi = b;
    repeat (3) @(negedge clk);
    spi.sck = 1'b1;
    repeat (4) @(negedge clk);
    spi.sck = 1'b0;
    @(negedge clk);
  endtask

  // Sends n bits of val (MSB first); optionally pulses sample_tick in the
  // exact cycle the DUT sees the cs_n rise (two sync flops + edge register).
  task automatic spi_frame(input logic [31:0] val, input int n, input bit tick_at_rise);
    bit pend_before;
    int band, idx;
    pend_before = m_pending;
    spi.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) spi_bit(val[i]);
    repeat (3) @(negedge clk);
    spi.cs_n = 1'b1;
    if (tick_at_rise) begin
      repeat (2) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      chk("applied on tick at cs rise", 32'(applied), 32'(pend_before));
      if (pend_before) model_apply();
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    band = int'(val[23:20]);
    idx  = int'(val[19:16]);
    if (n != 24) exp_err++;
    else if (val[23:16] == 8'hFF) m_pending = 1'b1;
    else if (band < NB && idx < NC) m_shadow[band][idx] = val[15:0];
    else exp_err++;
    chk("frame_err count", 32'(err_seen), 32'(exp_err));
    chk("commit_pending after frame", 32'(commit_pending), 32'(m_pending));
  endtask

  task automatic tick();
    bit pend_before;
    pend_before = m_pending;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("applied on tick", 32'(applied), 32'(pend_before));
    if (pend_before) begin
      model_apply();
      check_bank("after apply");
    end
    chk("commit_pending after tick", 32'(commit_pending), 32'(m_pending));
    @(negedge clk);
    chk("applied is one cycle", 32'(applied), 32'd0);
  endtask

  initial begin
    logic [31:0] val;
    int sel;
    spi.sck = 1'b0;
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check_bank("reset");
    chk("reset commit_pending", 32'(commit_pending), 32'd0);
    chk("reset applied", 32'(applied), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);

    spi_frame(32'h12ABCD, 24, 1'b0);
    repeat (10) tick();
    chk("band1 b2 before commit", 32'(coef(1, 2)), 32'h0);
    check_bank("no commit");

    spi_frame(32'hFF0000, 24, 1'b0);
    tick();
    chk("band1 b2 after commit", 32'(coef(1, 2)), 32'hABCD);

    spi_frame(32'h3456, 23, 1'b0);
    spi_frame(32'h1ABCDEF, 25, 1'b0);
    spi_frame(32'h351111, 24, 1'b0);
    spi_frame(32'hFF0000, 24, 1'b0);
    tick();
    check_bank("after rejected frames");

    spi_frame(32'h045A5A, 24, 1'b0);
    spi_frame(32'hFF0000, 24, 1'b1);
    chk("pending survives coincident tick", 32'(commit_pending), 32'd1);
    tick();
    chk("band0 a2 applied next tick", 32'(coef(0, 4)), 32'h5A5A);

    spi.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    val = 32'h009999;
    for (int i = 23; i >= 12; i--) spi_bit(val[i]);
    reset = 1'b1;
    spi.cs_n = 1'b1;
    spi.sck = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_bank("mid-frame reset");
    chk("mid-frame reset pending", 32'(commit_pending), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    spi_frame(32'h001234, 24, 1'b0);
    spi_frame(32'hFF0000, 24, 1'b0);
    tick();
    chk("band0 b0 after reset write", 32'(coef(0, 0)), 32'h1234);

    for (int r = 0; r < 25; r++) begin
      sel = int'($urandom_range(0, 9));
      val = 32'h0;
      val[15:0] = 16'($urandom);
      if (sel < 6) begin
        val[23:20] = 4'($urandom_range(0, NB - 1));
        val[19:16] = 4'($urandom_range(0, NC - 1));
      end else if (sel < 8) begin
        val[23:16] = 8'($urandom_range(8'h30, 8'hFE));
      end else begin
        val[23:16] = 8'hFF;
      end
      spi_frame(val, 24, 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    spi_frame(32'hFF0000, 24, 1'b0);
    tick();
    check_bank("random final");
    repeat (2) @(negedge clk);
    chk("total applied pulses", 32'(applied_seen), 32'(exp_applied));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
